// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port data RAM (A = CPU MEM stage, B = debug/loader).
// Define DMEM_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round-robin.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  busy,
    output logic                  ram_we,
    output logic                  ram_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    logic   grant_b;
    logic   pick_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_b = b_req && !a_req;
    end
`else
    // 1 = port B won the most recent grant; a tie goes to the other port.
    logic last_grant;

    always_comb begin
        pick_b = b_req;
        if (a_req && b_req) begin
            pick_b = !last_grant;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_b   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            busy      <= 1'b0;
            ram_we    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant_b   <= pick_b;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_grant <= pick_b;
`endif
                        ram_addr  <= pick_b ? b_addr : a_addr;
                        ram_wdata <= pick_b ? b_wdata : a_wdata;
                        ram_we    <= pick_b ? b_we : a_we;
                        ram_rd    <= pick_b ? !b_we : !a_we;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM read data is combinational, so it is valid at this closing edge.
                    if (ram_rd) begin
                        if (grant_b) begin
                            b_rdata <= ram_rdata;
                        end else begin
                            a_rdata <= ram_rdata;
                        end
                    end
                    ram_we <= 1'b0;
                    ram_rd <= 1'b0;
                    a_ack  <= !grant_b;
                    b_ack  <= grant_b;
                    state  <= RESP;
                end
                RESP: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
